// File: rtl/sensor_cond_pkg.sv
// Shared constants and types for the sensor conditioner slice.
// The optional tamper logic is selected by the SENSOR_COND_TAMPER_EN macro in sensor_conditioner.
package sensor_cond_pkg;

  localparam int NUM_CH           = 3;
  localparam int CH_ARM           = 0;
  localparam int CH_BREACH        = 1;
  localparam int CH_CONFIRM       = 2;

  localparam int DEB_CYCLES_DEF   = 4;
  localparam int GLITCH_LIMIT_DEF = 8;
  localparam int GLITCH_CNT_W     = 4;

  typedef logic [NUM_CH-1:0] ch_vec_t;

  // Debounce counter width; never narrower than one bit.
  function automatic int cnt_width(input int deb_cycles);
    return (deb_cycles <= 2) ? 1 : $clog2(deb_cycles);
  endfunction

endpackage

// File: rtl/sensor_cond_if.sv
// Sensor conditioner signal bundle: raw sensors and clear in, conditioned levels/pulses and tamper out.
// master = sensor/host side, slave = conditioner side.
interface sensor_cond_if;
  import sensor_cond_pkg::*;

  ch_vec_t sensor_raw;
  logic    clear;
  ch_vec_t cond_level;
  ch_vec_t cond_rise;
  logic    tamper;

  modport master (
    output sensor_raw,
    output clear,
    input  cond_level,
    input  cond_rise,
    input  tamper
  );

  modport slave (
    input  sensor_raw,
    input  clear,
    output cond_level,
    output cond_rise,
    output tamper
  );

endinterface

// File: rtl/sensor_debounce_ch.sv
// One sensor channel: 2-flop synchronizer, debounce counter with stable level,
// registered rise pulse and a combinational glitch strobe for tamper counting.
module sensor_debounce_ch
  import sensor_cond_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic glitch
);

  localparam int             CNT_W    = cnt_width(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1_reg;
  logic             sync2_reg;
  logic             stable_reg, stable_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             rise_reg, rise_next;
  logic             differ;

  assign differ = (sync2_reg != stable_reg);

  // Qualifying compare is checked before incrementing, so the counter never wraps.
  always_comb begin
    stable_next = stable_reg;
    cnt_next    = '0;
    rise_next   = 1'b0;
    if (differ) begin
      if (cnt_reg == CNT_LAST) begin
        stable_next = sync2_reg;
        rise_next   = sync2_reg;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg  <= 1'b0;
      sync2_reg  <= 1'b0;
      stable_reg <= 1'b0;
      cnt_reg    <= '0;
      rise_reg   <= 1'b0;
    end else begin
      sync1_reg  <= raw;
      sync2_reg  <= sync1_reg;
      stable_reg <= stable_next;
      cnt_reg    <= cnt_next;
      rise_reg   <= rise_next;
    end
  end

  // A glitch is an abandoned qualification: counter falls back to zero without a level change.
  assign glitch = !differ && (cnt_reg != '0);
  assign level  = stable_reg;
  assign rise   = rise_reg;

endmodule

// File: rtl/sensor_conditioner.sv
// Debounces the arm/breach/confirm sensors and optionally flags tamper on repeated glitches.
// Define SENSOR_COND_TAMPER_EN to build the per-channel glitch counters and sticky tamper flag.
module sensor_conditioner
  import sensor_cond_pkg::*;
#(
  parameter int DEB_CYCLES   = DEB_CYCLES_DEF,
  parameter int GLITCH_LIMIT = GLITCH_LIMIT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  sensor_cond_if.slave  sio
);

  localparam logic [GLITCH_CNT_W-1:0] LIMIT_V = GLITCH_CNT_W'(GLITCH_LIMIT);

  ch_vec_t level_vec;
  ch_vec_t rise_vec;
  ch_vec_t glitch_vec;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      sensor_debounce_ch #(
        .DEB_CYCLES (DEB_CYCLES)
      ) u_ch (
        .clk    (clk),
        .rst    (rst),
        .raw    (sio.sensor_raw[gi]),
        .level  (level_vec[gi]),
        .rise   (rise_vec[gi]),
        .glitch (glitch_vec[gi])
      );
    end
  endgenerate

  assign sio.cond_level = level_vec;
  assign sio.cond_rise  = rise_vec;

`ifdef SENSOR_COND_TAMPER_EN
  ch_vec_t at_limit;
  logic    tamper_reg, tamper_next;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_glitch
      logic [GLITCH_CNT_W-1:0] gcnt_reg, gcnt_next;

      // clear outranks a glitch landing in the same cycle.
      always_comb begin
        gcnt_next = gcnt_reg;
        if (sio.clear) begin
          gcnt_next = '0;
        end else if (glitch_vec[gi] && (gcnt_reg != LIMIT_V)) begin
          gcnt_next = gcnt_reg + 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          gcnt_reg <= '0;
        end else begin
          gcnt_reg <= gcnt_next;
        end
      end

      assign at_limit[gi] = (gcnt_reg == LIMIT_V);
    end
  endgenerate

  always_comb begin
    tamper_next = tamper_reg | (|at_limit);
    if (sio.clear) begin
      tamper_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tamper_reg <= 1'b0;
    end else begin
      tamper_reg <= tamper_next;
    end
  end

  assign sio.tamper = tamper_reg;
`else
  logic unused_tamper_inputs;
  assign unused_tamper_inputs = ^{glitch_vec, sio.clear, LIMIT_V};
  assign sio.tamper           = 1'b0;
`endif

endmodule
